// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential divider: FSM states, ALU op codes, iteration counts.
// Defining MULDIV_RV64W_EN makes the 32-bit W op codes decode as supported.
package muldiv_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} stateT;

  localparam logic [5:0] OP_DIV   = 6'b100011;
  localparam logic [5:0] OP_DIVU  = 6'b100100;
  localparam logic [5:0] OP_REM   = 6'b100101;
  localparam logic [5:0] OP_REMU  = 6'b100110;
  localparam logic [5:0] OP_DIVW  = 6'b101000;
  localparam logic [5:0] OP_DIVUW = 6'b101001;
  localparam logic [5:0] OP_REMW  = 6'b101010;
  localparam logic [5:0] OP_REMUW = 6'b101011;

  localparam logic [6:0] ITER_64 = 7'd64;
  localparam logic [6:0] ITER_32 = 7'd32;

  typedef struct packed {
    logic supported;
    logic isSigned;
    logic isRem;
    logic isWord;
  } opInfoT;

  function automatic opInfoT decodeOp(input logic [5:0] op);
    opInfoT info;
    info = '0;
    case (op)
      OP_DIV:   info = '{supported: 1'b1, isSigned: 1'b1, isRem: 1'b0, isWord: 1'b0};
      OP_DIVU:  info = '{supported: 1'b1, isSigned: 1'b0, isRem: 1'b0, isWord: 1'b0};
      OP_REM:   info = '{supported: 1'b1, isSigned: 1'b1, isRem: 1'b1, isWord: 1'b0};
      OP_REMU:  info = '{supported: 1'b1, isSigned: 1'b0, isRem: 1'b1, isWord: 1'b0};
`ifdef MULDIV_RV64W_EN
      OP_DIVW:  info = '{supported: 1'b1, isSigned: 1'b1, isRem: 1'b0, isWord: 1'b1};
      OP_DIVUW: info = '{supported: 1'b1, isSigned: 1'b0, isRem: 1'b0, isWord: 1'b1};
      OP_REMW:  info = '{supported: 1'b1, isSigned: 1'b1, isRem: 1'b1, isWord: 1'b1};
      OP_REMUW: info = '{supported: 1'b1, isSigned: 1'b0, isRem: 1'b1, isWord: 1'b1};
`else
`endif
      default:  info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the partial remainder
// and subtract the divisor when it fits.
module div_step (
  input  logic [63:0] partRem,
  input  logic [63:0] divisor,
  input  logic        bitIn,
  output logic [63:0] nextRem,
  output logic        quoBit
);

  logic [64:0] shifted;
  logic [64:0] diff;

  // partRem < divisor always holds, so 65 bits cover the shifted value and the borrow.
  assign shifted = {partRem, bitIn};
  assign diff    = shifted - {1'b0, divisor};
  assign quoBit  = ~diff[64];
  assign nextRem = quoBit ? diff[63:0] : shifted[63:0];

endmodule

// File: rtl/muldiv_seq.sv
// Sequential radix-2 divide/remainder unit for the EX stage, one quotient bit per cycle.
// W ops are only decoded as supported when MULDIV_RV64W_EN is defined (see muldiv_pkg).
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inStart,
  input  logic [5:0]  inAluControl,
  input  logic [63:0] inDataA,
  input  logic [63:0] inDataB,
  input  logic        inFlush,
  input  logic        in_stall_from_dcache,
  input  logic        in_stall_from_icache,
  output logic        outStall,
  output logic        outValid,
  output logic [63:0] outResult,
  output logic        outBusy,
  output logic        outIllegal
);

  stateT       state, nextState;
  opInfoT      opInfo;
  logic        cacheStall, startReq, divZero, overflow, negA, negB;
  logic [63:0] extA, extB, magA, magB, minVal, specialResult;
  logic [63:0] remReg, quoReg, divisorReg, stepRem, fixQuo, fixRem, fixSel;
  logic        stepBit, negQuo, negRem, remOp, wordOp;
  logic [6:0]  iterCount;

  assign opInfo     = decodeOp(inAluControl);
  assign cacheStall = in_stall_from_dcache | in_stall_from_icache;
  assign startReq   = (state == IDLE) && inStart && opInfo.supported;

  // W ops see only the low word, extended according to signedness, so one datapath serves both.
  always_comb begin
    extA = inDataA;
    extB = inDataB;
    if (opInfo.isWord) begin
      extA = {{32{opInfo.isSigned & inDataA[31]}}, inDataA[31:0]};
      extB = {{32{opInfo.isSigned & inDataB[31]}}, inDataB[31:0]};
    end
    negA     = opInfo.isSigned & extA[63];
    negB     = opInfo.isSigned & extB[63];
    magA     = negA ? -extA : extA;
    magB     = negB ? -extB : extB;
    minVal   = opInfo.isWord ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    divZero  = (extB == '0);
    overflow = opInfo.isSigned && (extA == minVal) && (extB == '1);
    if (divZero)
      specialResult = opInfo.isRem
                      ? (opInfo.isWord ? {{32{inDataA[31]}}, inDataA[31:0]} : inDataA)
                      : '1;
    else
      specialResult = opInfo.isRem ? '0 : minVal;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Flush beats everything; a cache stall freezes the FSM where it stands.
  always_comb begin
    nextState  = state;
    outBusy    = (state != IDLE);
    outValid   = (state == DONE) && !inFlush;
    outStall   = reset_n && (startReq || (state == CALC) || (state == FIXUP));
    outIllegal = reset_n && (state == IDLE) && inStart && !opInfo.supported
                 && !inFlush && !cacheStall;
    if (inFlush) begin
      nextState = IDLE;
    end else if (!cacheStall) begin
      case (state)
        IDLE:    if (startReq) nextState = (divZero || overflow) ? DONE : CALC;
        CALC:    if (iterCount == 7'd1) nextState = FIXUP;
        FIXUP:   nextState = DONE;
        DONE:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  div_step uStep (
    .partRem (remReg),
    .divisor (divisorReg),
    .bitIn   (quoReg[63]),
    .nextRem (stepRem),
    .quoBit  (stepBit)
  );

  assign fixQuo = negQuo ? -quoReg : quoReg;
  assign fixRem = negRem ? -remReg : remReg;
  assign fixSel = remOp ? fixRem : fixQuo;

  // Dividend magnitude sits left-justified in quoReg so its MSB feeds each step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      iterCount  <= '0;
      negQuo     <= 1'b0;
      negRem     <= 1'b0;
      remOp      <= 1'b0;
      wordOp     <= 1'b0;
      outResult  <= '0;
    end else if (!inFlush && !cacheStall) begin
      case (state)
        IDLE: begin
          if (startReq) begin
            remReg     <= '0;
            quoReg     <= opInfo.isWord ? {magA[31:0], 32'b0} : magA;
            divisorReg <= magB;
            iterCount  <= opInfo.isWord ? ITER_32 : ITER_64;
            negQuo     <= negA ^ negB;
            negRem     <= negA;
            remOp      <= opInfo.isRem;
            wordOp     <= opInfo.isWord;
            if (divZero || overflow) outResult <= specialResult;
          end
        end
        CALC: begin
          remReg    <= stepRem;
          quoReg    <= {quoReg[62:0], stepBit};
          iterCount <= iterCount - 7'd1;
        end
        FIXUP: outResult <= wordOp ? {{32{fixSel[31]}}, fixSel[31:0]} : fixSel;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes arithmetic-model results, a monitor pops on outValid.
// W-op expectations follow MULDIV_RV64W_EN exactly as the design does.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk, reset_n, inStart, inFlush, dStall, iStall;
  logic [5:0]  inAluControl;
  logic [63:0] inDataA, inDataB;
  logic        outStall, outValid, outBusy, outIllegal;
  logic [63:0] outResult;

  int vectors = 0;
  int miscompares = 0;
  int cycleCnt = 0;

  typedef struct {
    logic [63:0] result;
    int          validCycle;
  } expT;
  expT sbQ[$];

  muldiv_seq dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .inStart              (inStart),
    .inAluControl         (inAluControl),
    .inDataA              (inDataA),
    .inDataB              (inDataB),
    .inFlush              (inFlush),
    .in_stall_from_dcache (dStall),
    .in_stall_from_icache (iStall),
    .outStall             (outStall),
    .outValid             (outValid),
    .outResult            (outResult),
    .outBusy              (outBusy),
    .outIllegal           (outIllegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt++;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  function automatic bit isWordOp(input logic [5:0] op);
    return op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic bit isSignedOp(input logic [5:0] op);
    return op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction

  function automatic bit opSupported(input logic [5:0] op);
    bit known;
    known = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
`ifdef MULDIV_RV64W_EN
    return known;
`else
    return known && !isWordOp(op);
`endif
  endfunction

  function automatic bit isSpecial(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
    if (isWordOp(op))
      return (b[31:0] == 32'd0) ||
             (isSignedOp(op) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) ||
           (isSignedOp(op) && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference results straight from the RISC-V M-extension division rules.
  function automatic logic [63:0] refModel(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              sa32, sb32;
    int unsigned     ua32, ub32;
    logic [63:0]     r;
    logic [31:0]     r32;
    bit              ovf;
    sa = a;  sb = b;  ua = a;  ub = b;
    sa32 = a[31:0];  sb32 = b[31:0];  ua32 = a[31:0];  ub32 = b[31:0];
    ovf = isSpecial(op, a, b) && isSignedOp(op);
    r = '0;
    r32 = '0;
    case (op)
      OP_DIV:   if (b == 0) r = '1; else if (ovf) r = a; else r = 64'(sa / sb);
      OP_REM:   if (b == 0) r = a;  else if (ovf) r = '0; else r = 64'(sa % sb);
      OP_DIVU:  if (b == 0) r = '1; else r = ua / ub;
      OP_REMU:  if (b == 0) r = a;  else r = ua % ub;
      OP_DIVW:  begin
                  if (b[31:0] == 0) r32 = '1; else if (ovf) r32 = 32'h8000_0000; else r32 = 32'(sa32 / sb32);
                  r = sext32(r32);
                end
      OP_REMW:  begin
                  if (b[31:0] == 0) r32 = a[31:0]; else if (ovf) r32 = '0; else r32 = 32'(sa32 % sb32);
                  r = sext32(r32);
                end
      OP_DIVUW: begin
                  if (b[31:0] == 0) r32 = '1; else r32 = ua32 / ub32;
                  r = sext32(r32);
                end
      OP_REMUW: begin
                  if (b[31:0] == 0) r32 = a[31:0]; else r32 = ua32 % ub32;
                  r = sext32(r32);
                end
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Monitor: a result is consumed on the cycle outValid is seen with no cache stall holding it.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && outValid && !dStall && !iStall) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedValid", 64'(outValid), 64'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("result", outResult, e.result);
          checkOutput("validCycle", 64'(cycleCnt), 64'(e.validCycle));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                               input int stallAt, input int stallLen, input bit useIcache);
    bit          sup, stallNow;
    int          lat;
    logic [63:0] exp;
    expT         e;
    sup = opSupported(op);
    exp = refModel(op, a, b);
    lat = isSpecial(op, a, b) ? 1 : (isWordOp(op) ? 34 : 66);
    @(negedge clk);
    inStart = 1'b1;
    inAluControl = op;
    inDataA = a;
    inDataB = b;
    if (sup) begin
      e.result = exp;
      e.validCycle = cycleCnt + lat + stallLen;
      sbQ.push_back(e);
    end
    #1;
    checkOutput("startStall", 64'(outStall), 64'(sup));
    checkOutput("startIllegal", 64'(outIllegal), 64'(!sup));
    @(negedge clk);
    inStart = 1'b0;
    inAluControl = 6'($urandom);
    inDataA = {$urandom, $urandom};
    inDataB = {$urandom, $urandom};
    if (!sup) begin
      #1;
      checkOutput("illegalStaysIdle", 64'(outBusy), 64'd0);
      checkOutput("illegalPulseEnds", 64'(outIllegal), 64'd0);
    end else begin
      for (int k = 1; k <= lat + stallLen; k++) begin
        if (k > 1) @(negedge clk);
        stallNow = (stallLen > 0) && (k >= stallAt) && (k < stallAt + stallLen);
        if (useIcache) iStall = stallNow;
        else           dStall = stallNow;
        #1;
        checkOutput("outStall", 64'(outStall), 64'(k < lat + stallLen));
      end
      dStall = 1'b0;
      iStall = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("holdResult", outResult, exp);
      checkOutput("backToIdle", 64'(outBusy), 64'd0);
    end
  endtask

  task automatic flushTest();
    int validSeen;
    validSeen = 0;
    @(negedge clk);
    inStart = 1'b1;
    inAluControl = OP_DIVU;
    inDataA = {$urandom, $urandom};
    inDataB = 64'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      inStart = 1'b0;
    end
    inFlush = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("flushToIdle", 64'(outBusy), 64'd0);
    inStart = 1'b1;
    inAluControl = OP_DIVU;
    #1;
    checkOutput("flushBlocksIllegal", 64'(outIllegal), 64'd0);
    @(negedge clk);
    inFlush = 1'b0;
    inStart = 1'b0;
    #1;
    checkOutput("flushBeatsStart", 64'(outBusy), 64'd0);
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      #1;
      if (outValid) validSeen++;
    end
    checkOutput("flushNoValid", 64'(validSeen), 64'd0);
  endtask

  task automatic resetTest();
    @(negedge clk);
    inStart = 1'b1;
    inAluControl = OP_DIV;
    inDataA = 64'd1_000_000;
    inDataB = 64'd9;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      inStart = 1'b0;
    end
    reset_n = 1'b0;
    inStart = 1'b1;
    #1;
    checkOutput("rstBusy", 64'(outBusy), 64'd0);
    checkOutput("rstStall", 64'(outStall), 64'd0);
    checkOutput("rstValid", 64'(outValid), 64'd0);
    checkOutput("rstIllegal", 64'(outIllegal), 64'd0);
    checkOutput("rstResult", outResult, 64'd0);
    @(negedge clk);
    inStart = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [5:0]  opList [8];
    logic [5:0]  op;
    logic [63:0] a, b;
    opList = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    reset_n = 1'b0;
    inStart = 1'b1;
    inAluControl = OP_DIVU;
    inDataA = 64'd100;
    inDataB = 64'd7;
    inFlush = 1'b0;
    dStall = 1'b0;
    iStall = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("resetStall", 64'(outStall), 64'd0);
    checkOutput("resetBusy", 64'(outBusy), 64'd0);
    checkOutput("resetValid", 64'(outValid), 64'd0);
    checkOutput("resetResult", outResult, 64'd0);
    inStart = 1'b0;
    reset_n = 1'b1;

    applyStimulus(OP_DIVU, 64'd100, 64'd7, 0, 0, 1'b0);
    applyStimulus(OP_REMU, 64'd100, 64'd7, 0, 0, 1'b0);
    applyStimulus(OP_DIV, -64'sd7, 64'sd2, 0, 0, 1'b0);
    applyStimulus(OP_REM, -64'sd7, 64'sd2, 0, 0, 1'b0);
    applyStimulus(OP_DIV, 64'd5, 64'd0, 0, 0, 1'b0);
    applyStimulus(OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1'b0);
    applyStimulus(OP_DIVW, 64'h0000_0000_8000_0000, 64'd1, 0, 0, 1'b0);
    applyStimulus(OP_DIVU, 64'd100, 64'd7, 10, 5, 1'b0);
    applyStimulus(OP_REM, -64'sd12345, 64'sd77, 30, 3, 1'b1);
    applyStimulus(6'b000001, 64'd9, 64'd3, 0, 0, 1'b0);

    for (int n = 0; n < 14; n++) begin
      op = opList[$urandom_range(0, 7)];
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 6))
        0: b = 64'd0;
        1: b = 64'hFFFF_FFFF_FFFF_FFFF;
        2: b = 64'($urandom_range(1, 50));
        3: a = isWordOp(op) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        default: ;
      endcase
      applyStimulus(op, a, b, 0, 0, 1'b0);
    end

    flushTest();
    resetTest();
    applyStimulus(OP_DIVU, 64'd100, 64'd7, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("pendingResults", 64'(sbQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
